uio_bus_arbiter: RTL and testbench

- Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the tt_um_fiumad top among NUM_REQ internal requesters.
- Round-robin arbitration, registered pad drive, and a guaranteed bus-turnaround gap after any output ownership.
- Sits between the project's internal engines and the uio pins; it is the only logic allowed to drive uio_out/uio_oe.

---
 rtl/uio_bus_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared 8-bit uio pad bus.
// Grants one internal requester at a time. Drives the pads only from registers.
// After every write owner it inserts a bus-turnaround gap of TURN_CYCLES cycles.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ena             design enable; 0 blocks new grants and releases the bus
//   req/dir/last    per-requester request, direction (1=drive), final-cycle flag
//   wdata           per-requester write byte, slice i = [8i+7:8i]
//   gnt/owner/busy  registered one-hot grant, owner index, not-idle flag
//   rdata           registered sample of uio_in while a read owner holds the bus
//   uio_in/out/oe   pad input, registered pad output, registered pad enable
//   timeout         (UIO_ARB_TIMEOUT_EN only) one-cycle pulse on a hold timeout
//
// Optional feature macro: UIO_ARB_TIMEOUT_EN enables the MAX_HOLD hold limit.
module uio_bus_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned MAX_HOLD    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     dir,
  input  logic [8*NUM_REQ-1:0]   wdata,
  input  logic [NUM_REQ-1:0]     last,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic [7:0]             rdata,
  input  logic [7:0]             uio_in,
  output logic [7:0]             uio_out,
  output logic [7:0]             uio_oe
`ifdef UIO_ARB_TIMEOUT_EN
  ,
  output logic                   timeout
`endif
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SUM_W  = IDX_W + 1;
  localparam int unsigned TCNT_W = 3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TURN_CYCLES == 0 || TURN_CYCLES > 7 ||
      MAX_HOLD == 0 || MAX_HOLD > 255) begin : g_bad_params
    $error("uio_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t               r_state, w_state_d;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_d;
  logic [IDX_W-1:0]     r_owner, w_owner_d;
  logic [IDX_W-1:0]     r_ptr, w_ptr_d;
  logic                 r_dir, w_dir_d;
  logic                 r_busy;
  logic [7:0]           r_out, w_out_d;
  logic [7:0]           r_oe, w_oe_d;
  logic [7:0]           r_rdata, w_rdata_d;
  logic [TCNT_W-1:0]    r_turn, w_turn_d;
  logic                 w_exit;
  logic                 w_hold_hit;

  logic [NUM_REQ-1:0]   w_req_rot;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W-1:0]     w_sel;
  logic [SUM_W-1:0]     w_sum;
  logic [IDX_W-1:0]     w_ptr_next;
  logic [7:0]           w_sel_wdata;
  logic [7:0]           w_own_wdata;
  logic                 w_own_req;
  logic                 w_own_last;

  // Rotate requests so bit 0 is the requester at the round-robin pointer.
  assign w_req_rot = NUM_REQ'({req, req} >> r_ptr);

  // First set request at or after the pointer.
  always_comb begin
    w_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) w_off = IDX_W'(j);
    end
  end

  assign w_sum = SUM_W'(r_ptr) + SUM_W'(w_off);
  assign w_sel = (w_sum >= SUM_W'(NUM_REQ)) ? IDX_W'(w_sum - SUM_W'(NUM_REQ))
                                            : IDX_W'(w_sum);

  // One-hot of the winner plus write-byte muxes for the winner and current owner.
  always_comb begin
    w_sel_oh    = '0;
    w_sel_wdata = '0;
    w_own_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_sel == IDX_W'(j)) begin
        w_sel_oh[j] = 1'b1;
        w_sel_wdata = wdata[8*j +: 8];
      end
      if (r_gnt[j]) w_own_wdata = wdata[8*j +: 8];
    end
  end

  assign w_own_req  = |(req & r_gnt);
  assign w_own_last = |(last & r_gnt);
  assign w_ptr_next = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

`ifdef UIO_ARB_TIMEOUT_EN
  logic [7:0] r_hold;
  logic       r_timeout;

  assign w_hold_hit = (r_hold + 8'd1) == 8'(MAX_HOLD);

  // Hold counter is zero on the grant edge and counts OWN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == S_OWN) && w_hold_hit;
      r_hold    <= (r_state == S_OWN) ? r_hold + 8'd1 : 8'd0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_hold_hit = 1'b0;
`endif

  // Next-state and next-output logic; every pad/grant output is registered.
  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_owner_d = r_owner;
    w_ptr_d   = r_ptr;
    w_dir_d   = r_dir;
    w_out_d   = r_out;
    w_oe_d    = r_oe;
    w_rdata_d = r_rdata;
    w_turn_d  = r_turn;
    w_exit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ena && (|req)) begin
          w_state_d = S_OWN;
          w_gnt_d   = w_sel_oh;
          w_owner_d = w_sel;
          w_dir_d   = |(dir & w_sel_oh);
          if (w_dir_d) begin
            w_oe_d  = 8'hFF;
            w_out_d = w_sel_wdata;
          end else begin
            w_oe_d  = 8'h00;
          end
        end
      end
      S_OWN: begin
        w_exit = w_own_last || !w_own_req || !ena || w_hold_hit;
        if (!r_dir) w_rdata_d = uio_in;
        if (w_exit) begin
          w_gnt_d   = '0;
          w_ptr_d   = w_ptr_next;
          w_oe_d    = 8'h00;
          w_turn_d  = '0;
          w_state_d = r_dir ? S_TURN : S_IDLE;
        end else if (r_dir) begin
          w_oe_d  = 8'hFF;
          w_out_d = w_own_wdata;
        end
      end
      S_TURN: begin
        w_oe_d  = 8'h00;
        w_gnt_d = '0;
        if (r_turn == TCNT_W'(TURN_CYCLES - 1)) begin
          w_state_d = S_IDLE;
        end else begin
          w_turn_d  = r_turn + TCNT_W'(1);
        end
      end
      default: begin
        w_state_d = S_IDLE;
        w_gnt_d   = '0;
        w_oe_d    = 8'h00;
      end
    endcase
  end

  // State and output registers; reset releases the pads immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_out   <= '0;
      r_oe    <= '0;
      r_rdata <= '0;
      r_turn  <= '0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_owner <= w_owner_d;
      r_ptr   <= w_ptr_d;
      r_dir   <= w_dir_d;
      r_busy  <= (w_state_d != S_IDLE);
      r_out   <= w_out_d;
      r_oe    <= w_oe_d;
      r_rdata <= w_rdata_d;
      r_turn  <= w_turn_d;
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign rdata   = r_rdata;
  assign uio_out = r_out;
  assign uio_oe  = r_oe;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter (NUM_REQ=4, TURN_CYCLES=1, MAX_HOLD=15).
module tb_uio_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [31:0] wdata;
  logic [3:0]  last;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic        busy;
  logic [7:0]  rdata;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
`ifdef UIO_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  uio_bus_arbiter #(
    .NUM_REQ     (4),
    .TURN_CYCLES (1),
    .MAX_HOLD    (15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .wdata   (wdata),
    .last    (last),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .rdata   (rdata),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
`ifdef UIO_ARB_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic [3:0] req;
    logic [3:0] dir;
    logic [3:0] last;
    logic [7:0] uin;
    logic [3:0] gnt;
    logic [2:0] owner;
    logic       busy;
    logic [7:0] oe;
    logic [7:0] out;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic e_ena, input logic [3:0] e_req,
                              input logic [3:0] e_dir, input logic [3:0] e_last,
                              input logic [7:0] e_uin, input logic [3:0] x_gnt,
                              input logic [2:0] x_owner, input logic x_busy,
                              input logic [7:0] x_oe, input logic [7:0] x_out,
                              input logic [7:0] x_rdata);
    vec_t v;
    v.ena = e_ena; v.req = e_req; v.dir = e_dir; v.last = e_last; v.uin = e_uin;
    v.gnt = x_gnt; v.owner = x_owner; v.busy = x_busy;
    v.oe = x_oe; v.out = x_out; v.rdata = x_rdata;
    vecs.push_back(v);
  endfunction

  initial begin
    // Each row: inputs driven for one cycle, then outputs expected after the next edge.
    // Round robin, all reads, last held high: grants 0,1,2,3,0 with an IDLE gap.
    add(1, 4'hF, 4'h0, 4'hF, 8'h10, 4'h1, 3'd0, 1, 8'h00, 8'h00, 8'h00);
    add(1, 4'hF, 4'h0, 4'hF, 8'h11, 4'h0, 3'd0, 0, 8'h00, 8'h00, 8'h11);
    add(1, 4'hF, 4'h0, 4'hF, 8'h12, 4'h2, 3'd1, 1, 8'h00, 8'h00, 8'h11);
    add(1, 4'hF, 4'h0, 4'hF, 8'h13, 4'h0, 3'd1, 0, 8'h00, 8'h00, 8'h13);
    add(1, 4'hF, 4'h0, 4'hF, 8'h14, 4'h4, 3'd2, 1, 8'h00, 8'h00, 8'h13);
    add(1, 4'hF, 4'h0, 4'hF, 8'h15, 4'h0, 3'd2, 0, 8'h00, 8'h00, 8'h15);
    add(1, 4'hF, 4'h0, 4'hF, 8'h16, 4'h8, 3'd3, 1, 8'h00, 8'h00, 8'h15);
    add(1, 4'hF, 4'h0, 4'hF, 8'h17, 4'h0, 3'd3, 0, 8'h00, 8'h00, 8'h17);
    add(1, 4'hF, 4'h0, 4'hF, 8'h18, 4'h1, 3'd0, 1, 8'h00, 8'h00, 8'h17);
    add(1, 4'h0, 4'h0, 4'h0, 8'h19, 4'h0, 3'd0, 0, 8'h00, 8'h00, 8'h19);
    // Write by 0 for three cycles, turnaround, then read by 1.
    add(1, 4'h1, 4'h1, 4'h0, 8'h5A, 4'h1, 3'd0, 1, 8'hFF, 8'h3C, 8'h19);
    add(1, 4'h3, 4'h1, 4'h0, 8'h5A, 4'h1, 3'd0, 1, 8'hFF, 8'h3C, 8'h19);
    add(1, 4'h3, 4'h1, 4'h0, 8'h5A, 4'h1, 3'd0, 1, 8'hFF, 8'h3C, 8'h19);
    add(1, 4'h3, 4'h1, 4'h1, 8'h5A, 4'h0, 3'd0, 1, 8'h00, 8'h3C, 8'h19);
    add(1, 4'h2, 4'h1, 4'h0, 8'h5A, 4'h0, 3'd0, 0, 8'h00, 8'h3C, 8'h19);
    add(1, 4'h2, 4'h1, 4'h0, 8'h5A, 4'h2, 3'd1, 1, 8'h00, 8'h3C, 8'h19);
    add(1, 4'h2, 4'h1, 4'h0, 8'h5A, 4'h2, 3'd1, 1, 8'h00, 8'h3C, 8'h5A);
    // Requester 2 raised and withdrawn while 1 owns: never granted.
    add(1, 4'h6, 4'h0, 4'h0, 8'h5B, 4'h2, 3'd1, 1, 8'h00, 8'h3C, 8'h5B);
    add(1, 4'h2, 4'h0, 4'h0, 8'h5C, 4'h2, 3'd1, 1, 8'h00, 8'h3C, 8'h5C);
    add(1, 4'h2, 4'h0, 4'h2, 8'h5D, 4'h0, 3'd1, 0, 8'h00, 8'h3C, 8'h5D);
    add(1, 4'h0, 4'h0, 4'h0, 8'h5E, 4'h0, 3'd1, 0, 8'h00, 8'h3C, 8'h5D);
    add(1, 4'h0, 4'h0, 4'h0, 8'h5F, 4'h0, 3'd1, 0, 8'h00, 8'h3C, 8'h5D);
    // Owner 3 writing; dir flip ignored; ena drop releases and blocks grants.
    add(1, 4'h8, 4'h8, 4'h0, 8'h60, 4'h8, 3'd3, 1, 8'hFF, 8'hD3, 8'h5D);
    add(1, 4'h8, 4'h0, 4'h0, 8'h61, 4'h8, 3'd3, 1, 8'hFF, 8'hD3, 8'h5D);
    add(0, 4'h8, 4'h8, 4'h0, 8'h62, 4'h0, 3'd3, 1, 8'h00, 8'hD3, 8'h5D);
    add(0, 4'h8, 4'h8, 4'h0, 8'h63, 4'h0, 3'd3, 0, 8'h00, 8'hD3, 8'h5D);
    add(0, 4'h8, 4'h8, 4'h0, 8'h64, 4'h0, 3'd3, 0, 8'h00, 8'hD3, 8'h5D);
    add(0, 4'h8, 4'h8, 4'h0, 8'h65, 4'h0, 3'd3, 0, 8'h00, 8'hD3, 8'h5D);
    add(1, 4'h8, 4'h8, 4'h0, 8'h66, 4'h8, 3'd3, 1, 8'hFF, 8'hD3, 8'h5D);
    add(1, 4'h0, 4'h8, 4'h0, 8'h67, 4'h0, 3'd3, 1, 8'h00, 8'hD3, 8'h5D);
    add(1, 4'h0, 4'h0, 4'h0, 8'h68, 4'h0, 3'd3, 0, 8'h00, 8'hD3, 8'h5D);

    rst    = 1'b1;
    ena    = 1'b0;
    req    = '0;
    dir    = '0;
    last   = '0;
    uio_in = '0;
    wdata  = {8'hD3, 8'hC2, 8'hB1, 8'h3C};
    #12;
    check("reset gnt",   32'(gnt),     32'h0);
    check("reset owner", 32'(owner),   32'h0);
    check("reset busy",  32'(busy),    32'h0);
    check("reset rdata", 32'(rdata),   32'h0);
    check("reset out",   32'(uio_out), 32'h0);
    check("reset oe",    32'(uio_oe),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ena    = vecs[i].ena;
      req    = vecs[i].req;
      dir    = vecs[i].dir;
      last   = vecs[i].last;
      uio_in = vecs[i].uin;
      exp_q.push_back(vecs[i]);
      step();
      e = exp_q.pop_front();
      check($sformatf("vec%0d gnt", i),   32'(gnt),     32'(e.gnt));
      check($sformatf("vec%0d owner", i), 32'(owner),   32'(e.owner));
      check($sformatf("vec%0d busy", i),  32'(busy),    32'(e.busy));
      check($sformatf("vec%0d oe", i),    32'(uio_oe),  32'(e.oe));
      check($sformatf("vec%0d out", i),   32'(uio_out), 32'(e.out));
      check($sformatf("vec%0d rdata", i), 32'(rdata),   32'(e.rdata));
    end

    // Owner 1 writing; byte tracks wdata each cycle; async reset mid-cycle.
    ena          = 1'b1;
    req          = 4'h2;
    dir          = 4'h2;
    last         = 4'h0;
    wdata[15:8]  = 8'hA5;
    step();
    check("wr1 gnt", 32'(gnt),     32'h2);
    check("wr1 oe",  32'(uio_oe),  32'hFF);
    check("wr1 out", 32'(uio_out), 32'hA5);
    wdata[15:8]  = 8'hA6;
    step();
    check("wr1 follow out", 32'(uio_out), 32'hA6);
    #2;
    rst = 1'b1;
    #1;
    check("async rst oe",    32'(uio_oe),  32'h0);
    check("async rst out",   32'(uio_out), 32'h0);
    check("async rst gnt",   32'(gnt),     32'h0);
    check("async rst busy",  32'(busy),    32'h0);
    check("async rst rdata", 32'(rdata),   32'h0);
    req = 4'h0;
    @(negedge clk);
    rst = 1'b0;

    // Long hold by owner 0 with requester 1 waiting.
    req  = 4'h3;
    dir  = 4'h0;
    last = 4'h0;
    ena  = 1'b1;
    step();
    check("hold grant", 32'(gnt), 32'h1);
`ifdef UIO_ARB_TIMEOUT_EN
    for (int k = 1; k < 15; k++) begin
      step();
      check($sformatf("hold c%0d gnt", k + 1), 32'(gnt), 32'h1);
      check($sformatf("hold c%0d timeout", k + 1), 32'(timeout), 32'h0);
    end
    step();
    check("timeout exit gnt", 32'(gnt), 32'h0);
    check("timeout pulse", 32'(timeout), 32'h1);
    step();
    check("after timeout gnt", 32'(gnt), 32'h2);
    check("timeout one cycle", 32'(timeout), 32'h0);
`else
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("hold c%0d gnt", k + 1), 32'(gnt), 32'h1);
    end
    req = 4'h2;
    step();
    check("hold release gnt", 32'(gnt), 32'h0);
    step();
    check("next owner gnt", 32'(gnt), 32'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
